id_alu_stage: RTL and testbench
===============================

# id_alu_stage

Decode stage that turns a fetched MIPS instruction into the 15-bit one-hot ALU control word and the two ALU operands the execute-stage ALU consumes. It is registered: it holds a single ID/EX pipeline register under a valid/allowin handshake and supports stall and flush. It sits between the register-file read and the EX stage, and is the sole producer of the ALU's control and operand inputs.

## Interface
- No parameters. Widths are fixed at 32-bit data, 5-bit register index and 15-bit control.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds an instruction
- id_pc  in  32  PC of that instruction
- id_inst  in  32  instruction word
- rs_data  in  32  register-file value of inst[25:21]
- rt_data  in  32  register-file value of inst[20:16]
- flush  in  1  discard the ID/EX contents and the current ID input
- ex_allowin  in  1  EX can accept this cycle
- id_allowin  out  1  this stage can accept this cycle
- ex_valid  out  1  ID/EX register holds an instruction
- ex_pc  out  32  registered PC
- ex_alu_ctrl  out  15  one-hot ALU operation; all-zero makes the ALU output zero
- ex_da  out  32  ALU operand a
- ex_db  out  32  ALU operand b
- ex_dest  out  5  destination register
- ex_rf_we  out  1  register write enable
- ex_ov_en  out  1  overflow trap enabled (ADD, ADDI, SUB)
- ex_ri  out  1  reserved-instruction exception flag

## Operation
- ALU control bit indices:
  - 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 SLT, 5 SLTU, 6 AND
  - 7 NOR, 8 OR, 9 XOR, 10 SLL, 11 SRL, 12 SRA, 13 LUI
  - 14 reserved, always 0
- R-type (opcode 0), keyed on funct:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT, 0x2B SLTU
  - 0x00 SLL, 0x02 SRL, 0x03 SRA
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV (control bits as SLL/SRL/SRA)
- R-type operands:
  - da = rs_data
  - db = rt_data
  - dest = inst[15:11]
- R-type shift operands:
  - Immediate shifts: da = {27'b0, inst[10:6]}.
  - Variable shifts: da = {27'b0, rs_data[4:0]}.
  - All shifts: db = rt_data.
- I-type, keyed on opcode:
  - 0x08 ADDI→ADD, 0x09 ADDIU→ADDU
  - 0x0A SLTI→SLT, 0x0B SLTIU→SLTU
  - 0x0C ANDI→AND, 0x0D ORI→OR, 0x0E XORI→XOR
  - 0x0F LUI→LUI
- I-type operands:
  - da = rs_data, dest = inst[20:16].
  - db is sign-extended imm for 0x08–0x0B.
  - db is zero-extended imm for 0x0C–0x0E.
  - db is {16'b0, imm} for LUI.
- ex_rf_we = 1 for a recognised instruction with dest ≠ 0. inst = 0 (SLL $0) is therefore a NOP with rf_we = 0.
- Any other encoding:
  - ex_alu_ctrl = 0, ex_da = ex_db = 0
  - ex_rf_we = 0, ex_ov_en = 0, ex_ri = 1
  - ex_dest is don't-care, driven 0.
- ex_ov_en = 1 only for ADD, ADDI and SUB.

## Timing
- Combinational: id_allowin = !ex_valid || ex_allowin.
- Accept = id_valid && id_allowin && !flush.
- Every rising edge, in priority order:
  - flush → ex_valid ← 0, and nothing is captured.
  - accept → all ex_* registers load the decode result, and ex_valid ← 1.
  - ex_allowin (no accept) → ex_valid ← 0.
  - otherwise → hold all ex_* values (stall).
- Latency is 1 cycle from accept to ex_valid. Throughput is 1 instruction per cycle while ex_allowin is held high.
- Simultaneous accept and drain (ex_allowin = 1) is a normal back-to-back transfer with no bubble.
- During a stall (ex_valid = 1, ex_allowin = 0), ex_* outputs are stable and id_allowin = 0.
- Reset, asynchronous at any time, including mid-stall:
  - all ex_* registers go to 0, including ex_valid = 0
  - id_allowin is therefore 1
- Data registers may capture only on accept. Values when ex_valid = 0 are don't-care but must stay at 0 or the last value.

## Structure
- A shared package holds:
  - the 15 ALU control bit-index constants, used by both this stage and the ALU
  - the opcode and funct constants
  - ZeroWord
- Sub-module alu_op_decode: a purely combinational map from inst, rs_data and rt_data to ctrl, da, db, dest, rf_we, ov_en and ri.
- The top level holds the handshake logic and the ID/EX register.

## Test plan
- Reset release, then ADD $3,$1,$2 with rs = 5, rt = 7, ex_allowin = 1:
  - next cycle ex_valid = 1, ex_alu_ctrl = 15'h0001, da = 5, db = 7
  - ex_dest = 3, ex_rf_we = 1, ex_ov_en = 1
- ADDIU $4,$1,0xFFFF → db = 0xFFFFFFFF. ORI $4,$1,0xFFFF → db = 0x0000FFFF. LUI $4,0x1234 → ctrl = 15'h2000, db = 0x00001234.
- SRA $5,$6,3 with rt = 0x80000000 → ctrl = 15'h1000, da = 3, db = 0x80000000. SRAV with rs = 0x25 → da = 5.
- Opcode 0x3F, and also inst = 0:
  - 0x3F → ex_ri = 1, ctrl = 0, rf_we = 0
  - inst = 0 → ri = 0, ctrl = 15'h0400, rf_we = 0
- Stall, then release:
  - Hold ex_allowin = 0 for 3 cycles with new id_valid → ex_* stays unchanged and id_allowin = 0.
  - Release → the pending instruction is captured on the next edge.
- flush asserted together with id_valid → ex_valid = 0 on the next edge. Reset asserted mid-stall → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_alu_stage_pkg.sv
// Shared ALU control encoding, MIPS opcode/funct constants and decode record type
// for the ID stage and the execute-stage ALU.
package id_alu_stage_pkg;

  localparam int ALU_W    = 15;
  localparam int ALU_ADD  = 0;
  localparam int ALU_ADDU = 1;
  localparam int ALU_SUB  = 2;
  localparam int ALU_SUBU = 3;
  localparam int ALU_SLT  = 4;
  localparam int ALU_SLTU = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_NOR  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_XOR  = 9;
  localparam int ALU_SLL  = 10;
  localparam int ALU_SRL  = 11;
  localparam int ALU_SRA  = 12;
  localparam int ALU_LUI  = 13;
  localparam int ALU_RSVD = 14;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef struct packed {
    logic [ALU_W-1:0] ctrl;
    logic [31:0]      da;
    logic [31:0]      db;
    logic [4:0]       dest;
    logic             rf_we;
    logic             ov_en;
    logic             ri;
  } alu_dec_t;

  localparam int ALU_DEC_W = $bits(alu_dec_t);

  function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
    return 15'd1 << idx;
  endfunction

endpackage

// File: rtl/id_alu_stage_alu_op_decode.sv
// Combinational instruction decoder: ALU one-hot control, operands, destination
// and write/overflow/reserved-instruction flags.
module alu_op_decode
  import id_alu_stage_pkg::*;
(
  input  logic [31:0]      inst,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [ALU_W-1:0] ctrl,
  output logic [31:0]      da,
  output logic [31:0]      db,
  output logic [4:0]       dest,
  output logic             rf_we,
  output logic             ov_en,
  output logic             ri
);

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [31:0]      imm_sext_s;
  logic [31:0]      imm_zext_s;
  logic             known_s;
  logic [ALU_W-1:0] ctrl_s;
  logic [31:0]      da_s;
  logic [31:0]      db_s;
  logic [4:0]       dest_s;
  logic             rf_we_s;
  logic             ov_en_s;
  logic             ri_s;
  logic             unused_rs_field_s;

  assign opcode_s          = inst[31:26];
  assign funct_s           = inst[5:0];
  assign imm_sext_s        = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext_s        = {16'h0000, inst[15:0]};
  // operands arrive already read from the register file, so the rs index field is not needed
  assign unused_rs_field_s = ^inst[25:21];

  // decode opcode/funct into the ALU control word and operand selection
  always_comb begin
    known_s = 1'b1;
    ctrl_s  = 15'd0;
    da_s    = rs_data;
    db_s    = rt_data;
    dest_s  = inst[20:16];
    ov_en_s = 1'b0;
    rf_we_s = 1'b0;
    ri_s    = 1'b0;
    case (opcode_s)
      OP_SPECIAL: begin
        dest_s = inst[15:11];
        case (funct_s)
          FN_ADD:  begin ctrl_s = alu_onehot(ALU_ADD); ov_en_s = 1'b1; end
          FN_ADDU: ctrl_s = alu_onehot(ALU_ADDU);
          FN_SUB:  begin ctrl_s = alu_onehot(ALU_SUB); ov_en_s = 1'b1; end
          FN_SUBU: ctrl_s = alu_onehot(ALU_SUBU);
          FN_AND:  ctrl_s = alu_onehot(ALU_AND);
          FN_OR:   ctrl_s = alu_onehot(ALU_OR);
          FN_XOR:  ctrl_s = alu_onehot(ALU_XOR);
          FN_NOR:  ctrl_s = alu_onehot(ALU_NOR);
          FN_SLT:  ctrl_s = alu_onehot(ALU_SLT);
          FN_SLTU: ctrl_s = alu_onehot(ALU_SLTU);
          FN_SLL:  begin ctrl_s = alu_onehot(ALU_SLL); da_s = {27'd0, inst[10:6]}; end
          FN_SRL:  begin ctrl_s = alu_onehot(ALU_SRL); da_s = {27'd0, inst[10:6]}; end
          FN_SRA:  begin ctrl_s = alu_onehot(ALU_SRA); da_s = {27'd0, inst[10:6]}; end
          FN_SLLV: begin ctrl_s = alu_onehot(ALU_SLL); da_s = {27'd0, rs_data[4:0]}; end
          FN_SRLV: begin ctrl_s = alu_onehot(ALU_SRL); da_s = {27'd0, rs_data[4:0]}; end
          FN_SRAV: begin ctrl_s = alu_onehot(ALU_SRA); da_s = {27'd0, rs_data[4:0]}; end
          default: known_s = 1'b0;
        endcase
      end
      OP_ADDI:  begin ctrl_s = alu_onehot(ALU_ADD); db_s = imm_sext_s; ov_en_s = 1'b1; end
      OP_ADDIU: begin ctrl_s = alu_onehot(ALU_ADDU); db_s = imm_sext_s; end
      OP_SLTI:  begin ctrl_s = alu_onehot(ALU_SLT);  db_s = imm_sext_s; end
      OP_SLTIU: begin ctrl_s = alu_onehot(ALU_SLTU); db_s = imm_sext_s; end
      OP_ANDI:  begin ctrl_s = alu_onehot(ALU_AND);  db_s = imm_zext_s; end
      OP_ORI:   begin ctrl_s = alu_onehot(ALU_OR);   db_s = imm_zext_s; end
      OP_XORI:  begin ctrl_s = alu_onehot(ALU_XOR);  db_s = imm_zext_s; end
      OP_LUI:   begin ctrl_s = alu_onehot(ALU_LUI);  db_s = imm_zext_s; end
      default:  known_s = 1'b0;
    endcase

    // an unrecognised encoding must present a zero-output ALU and raise the RI flag
    if (known_s) begin
      rf_we_s = (dest_s != 5'd0);
    end else begin
      ctrl_s  = 15'd0;
      da_s    = ZeroWord;
      db_s    = ZeroWord;
      dest_s  = 5'd0;
      ov_en_s = 1'b0;
      rf_we_s = 1'b0;
      ri_s    = 1'b1;
    end
  end

  assign ctrl  = ctrl_s;
  assign da    = da_s;
  assign db    = db_s;
  assign dest  = dest_s;
  assign rf_we = rf_we_s;
  assign ov_en = ov_en_s;
  assign ri    = ri_s;

endmodule

// File: rtl/id_alu_stage.sv
// ID stage top: instruction decode feeding a single ID/EX pipeline register
// with valid/allowin handshake, stall and flush.
module id_alu_stage
  import id_alu_stage_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             flush,
  input  logic             ex_allowin,
  output logic             id_allowin,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [ALU_W-1:0] ex_alu_ctrl,
  output logic [31:0]      ex_da,
  output logic [31:0]      ex_db,
  output logic [4:0]       ex_dest,
  output logic             ex_rf_we,
  output logic             ex_ov_en,
  output logic             ex_ri
);

  logic [ALU_W-1:0] dec_ctrl_s;
  logic [31:0]      dec_da_s;
  logic [31:0]      dec_db_s;
  logic [4:0]       dec_dest_s;
  logic             dec_rf_we_s;
  logic             dec_ov_en_s;
  logic             dec_ri_s;
  alu_dec_t         dec_s;
  alu_dec_t         ex_r;
  logic [31:0]      ex_pc_r;
  logic             ex_valid_r;
  logic             allowin_s;
  logic             accept_s;

  alu_op_decode u_dec (
    .inst    (id_inst),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .ctrl    (dec_ctrl_s),
    .da      (dec_da_s),
    .db      (dec_db_s),
    .dest    (dec_dest_s),
    .rf_we   (dec_rf_we_s),
    .ov_en   (dec_ov_en_s),
    .ri      (dec_ri_s)
  );

  assign dec_s     = {dec_ctrl_s, dec_da_s, dec_db_s, dec_dest_s, dec_rf_we_s, dec_ov_en_s, dec_ri_s};
  assign allowin_s = !ex_valid_r || ex_allowin;
  assign accept_s  = id_valid && allowin_s && !flush;

  // occupancy of the ID/EX register: flush beats accept beats drain, else stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
    end else if (ex_allowin) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // payload registers capture only on accept so a stalled instruction stays stable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_pc_r <= ZeroWord;
      ex_r    <= {ALU_DEC_W{1'b0}};
    end else if (accept_s) begin
      ex_pc_r <= id_pc;
      ex_r    <= dec_s;
    end else begin
      ex_pc_r <= ex_pc_r;
      ex_r    <= ex_r;
    end
  end

  assign id_allowin  = allowin_s;
  assign ex_valid    = ex_valid_r;
  assign ex_pc       = ex_pc_r;
  assign ex_alu_ctrl = ex_r.ctrl;
  assign ex_da       = ex_r.da;
  assign ex_db       = ex_r.db;
  assign ex_dest     = ex_r.dest;
  assign ex_rf_we    = ex_r.rf_we;
  assign ex_ov_en    = ex_r.ov_en;
  assign ex_ri       = ex_r.ri;

endmodule

// File: tb/tb_id_alu_stage.sv
// Bench for id_alu_stage: directed decode table, handshake corner sequences,
// then randomized traffic against a behavioural model.
module tb_id_alu_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_allowin;
  logic        id_allowin;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [14:0] ex_alu_ctrl;
  logic [31:0] ex_da;
  logic [31:0] ex_db;
  logic [4:0]  ex_dest;
  logic        ex_rf_we;
  logic        ex_ov_en;
  logic        ex_ri;

  int total = 0;
  int bad   = 0;

  id_alu_stage dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_allowin(ex_allowin),
    .id_allowin(id_allowin), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_da(ex_da), .ex_db(ex_db), .ex_dest(ex_dest), .ex_rf_we(ex_rf_we),
    .ex_ov_en(ex_ov_en), .ex_ri(ex_ri)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] ctrl;
    logic [31:0] da;
    logic [31:0] db;
    logic [4:0]  dest;
    logic        we;
    logic        ov;
    logic        ri;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk_e(input logic [14:0] ctrl, input logic [31:0] da,
                                input logic [31:0] db, input logic [4:0] dest,
                                input logic we, input logic ov, input logic ri);
    exp_t e;
    e.ctrl = ctrl; e.da = da; e.db = db; e.dest = dest; e.we = we; e.ov = ov; e.ri = ri;
    return e;
  endfunction

  task automatic add_vec(input string name, input logic [31:0] inst, input logic [31:0] rs,
                         input logic [31:0] rt, input exp_t e);
    vec_t v;
    v.name = name; v.inst = inst; v.rs = rs; v.rt = rt; v.e = e;
    vecs.push_back(v);
  endtask

  // Reference: map the instruction to an ALU operation number, then apply the operand rules.
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] rs,
                                   input logic [31:0] rt);
    exp_t e;
    int op;
    int fn;
    int idx;
    op  = int'(inst[31:26]);
    fn  = int'(inst[5:0]);
    idx = -1;
    e   = mk_e(15'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    if (op == 0) begin
      case (fn)
        32: idx = 0;   33: idx = 1;   34: idx = 2;   35: idx = 3;
        42: idx = 4;   43: idx = 5;   36: idx = 6;   39: idx = 7;
        37: idx = 8;   38: idx = 9;
        0, 4: idx = 10;
        2, 6: idx = 11;
        3, 7: idx = 12;
        default: idx = -1;
      endcase
    end else begin
      case (op)
        8: idx = 0;  9: idx = 1;  10: idx = 4;  11: idx = 5;
        12: idx = 6; 13: idx = 8; 14: idx = 9;  15: idx = 13;
        default: idx = -1;
      endcase
    end
    if (idx < 0) begin
      e.ri = 1'b1;
      return e;
    end
    e.ctrl = 15'd1 << idx;
    if (op == 0) begin
      e.dest = inst[15:11];
      e.db   = rt;
      if (fn < 4)      e.da = 32'(inst[10:6]);
      else if (fn < 8) e.da = rs % 32;
      else             e.da = rs;
    end else begin
      e.dest = inst[20:16];
      e.da   = rs;
      if (op <= 11) e.db = (inst[15] ? 32'hFFFF0000 : 32'h0) + 32'(inst[15:0]);
      else          e.db = 32'(inst[15:0]);
    end
    e.ov = (idx == 0) || (idx == 2);
    e.we = (e.dest != 5'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".ctrl"}, 32'(ex_alu_ctrl), 32'(e.ctrl));
    chk({tag, ".da"},   ex_da, e.da);
    chk({tag, ".db"},   ex_db, e.db);
    chk({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
    chk({tag, ".we"},   32'(ex_rf_we), 32'(e.we));
    chk({tag, ".ov"},   32'(ex_ov_en), 32'(e.ov));
    chk({tag, ".ri"},   32'(ex_ri), 32'(e.ri));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] rs, input logic [31:0] rt);
    id_valid = v; id_pc = pc; id_inst = inst; rs_data = rs; rt_data = rt;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] x;
    logic [5:0]  fns [16];
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    x = $urandom;
    case ($urandom_range(0, 3))
      0: begin x[31:26] = 6'h00; x[5:0] = fns[$urandom_range(0, 15)]; end
      1: x[31:26] = 6'(6'h08 + $urandom_range(0, 7));
      2: x[31:26] = 6'h00;
      default: ;
    endcase
    return x;
  endfunction

  exp_t        m_e;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        acc;
  exp_t        ea;

  initial begin
    resetn = 1'b0; flush = 1'b0; ex_allowin = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    add_vec("add",   mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7,
            mk_e(15'h0001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0));
    add_vec("addiu", mk_i(6'h09, 5'd1, 5'd4, 16'hFFFF), 32'h11, 32'h22,
            mk_e(15'h0002, 32'h11, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0));
    add_vec("ori",   mk_i(6'h0D, 5'd1, 5'd4, 16'hFFFF), 32'h11, 32'h22,
            mk_e(15'h0100, 32'h11, 32'h0000FFFF, 5'd4, 1'b1, 1'b0, 1'b0));
    add_vec("lui",   mk_i(6'h0F, 5'd0, 5'd4, 16'h1234), 32'h0, 32'h9,
            mk_e(15'h2000, 32'h0, 32'h00001234, 5'd4, 1'b1, 1'b0, 1'b0));
    add_vec("sra",   mk_r(5'd0, 5'd6, 5'd5, 5'd3, 6'h03), 32'h99, 32'h80000000,
            mk_e(15'h1000, 32'd3, 32'h80000000, 5'd5, 1'b1, 1'b0, 1'b0));
    add_vec("srav",  mk_r(5'd7, 5'd6, 5'd5, 5'd0, 6'h07), 32'h25, 32'hF0,
            mk_e(15'h1000, 32'd5, 32'hF0, 5'd5, 1'b1, 1'b0, 1'b0));
    add_vec("op3f",  mk_i(6'h3F, 5'd1, 5'd2, 16'h5555), 32'h1, 32'h2,
            mk_e(15'h0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    add_vec("nop",   32'h0, 32'hAB, 32'hCD,
            mk_e(15'h0400, 32'h0, 32'hCD, 5'd0, 1'b0, 1'b0, 1'b0));
    add_vec("sub",   mk_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h22), 32'd100, 32'd30,
            mk_e(15'h0004, 32'd100, 32'd30, 5'd10, 1'b1, 1'b1, 1'b0));
    add_vec("sltiu", mk_i(6'h0B, 5'd2, 5'd7, 16'h8000), 32'd3, 32'd1,
            mk_e(15'h0020, 32'd3, 32'hFFFF8000, 5'd7, 1'b1, 1'b0, 1'b0));
    add_vec("andi",  mk_i(6'h0C, 5'd2, 5'd7, 16'h8000), 32'd3, 32'd1,
            mk_e(15'h0040, 32'd3, 32'h00008000, 5'd7, 1'b1, 1'b0, 1'b0));
    add_vec("badfn", mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h01), 32'd4, 32'd6,
            mk_e(15'h0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    add_vec("addi0", mk_i(6'h08, 5'd1, 5'd0, 16'h0010), 32'd5, 32'd6,
            mk_e(15'h0001, 32'd5, 32'h10, 5'd0, 1'b0, 1'b1, 1'b0));
    add_vec("nor",   mk_r(5'd1, 5'd2, 5'd31, 5'd0, 6'h27), 32'd1, 32'd2,
            mk_e(15'h0080, 32'd1, 32'd2, 5'd31, 1'b1, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.allowin", 32'(id_allowin), 32'd1);
    chk("rst.pc", ex_pc, 32'd0);
    chk_out("rst", mk_e(15'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    resetn = 1'b1;

    // back-to-back decode table
    foreach (vecs[i]) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), vecs[i].inst, vecs[i].rs, vecs[i].rt);
      @(negedge clk);
      chk({vecs[i].name, ".valid"}, 32'(ex_valid), 32'd1);
      chk({vecs[i].name, ".pc"}, ex_pc, 32'h1000 + 32'(i * 4));
      chk_out(vecs[i].name, vecs[i].e);
    end

    // stall for three cycles, then release
    drive(1'b1, 32'h2000, vecs[0].inst, vecs[0].rs, vecs[0].rt);
    @(negedge clk);
    ex_allowin = 1'b0;
    drive(1'b1, 32'h2004, vecs[8].inst, vecs[8].rs, vecs[8].rt);
    #1 chk("stall.allowin0", 32'(id_allowin), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall.valid", 32'(ex_valid), 32'd1);
      chk("stall.pc", ex_pc, 32'h2000);
      chk("stall.allowin", 32'(id_allowin), 32'd0);
      chk_out("stall", vecs[0].e);
    end
    ex_allowin = 1'b1;
    #1 chk("release.allowin", 32'(id_allowin), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("release.pc", ex_pc, 32'h2004);
    chk("release.valid", 32'(ex_valid), 32'd1);
    chk_out("release", vecs[8].e);

    // flush with an incoming instruction
    drive(1'b1, 32'h3000, vecs[1].inst, vecs[1].rs, vecs[1].rt);
    flush = 1'b1;
    @(negedge clk);
    chk("flush.valid", 32'(ex_valid), 32'd0);
    // flush while stalled
    flush = 1'b0;
    @(negedge clk);
    chk("flush.reload", 32'(ex_valid), 32'd1);
    ex_allowin = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush.stalled", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_allowin = 1'b1;

    // asynchronous reset in the middle of a stall
    drive(1'b1, 32'h4000, vecs[0].inst, vecs[0].rs, vecs[0].rt);
    @(negedge clk);
    ex_allowin = 1'b0;
    drive(1'b1, 32'h4004, vecs[2].inst, vecs[2].rs, vecs[2].rt);
    #2 resetn = 1'b0;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.allowin", 32'(id_allowin), 32'd1);
    chk("arst.pc", ex_pc, 32'd0);
    chk_out("arst", mk_e(15'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    ex_allowin = 1'b1;
    @(negedge clk);
    resetn = 1'b1;

    // randomized traffic against the behavioural model
    m_valid = 1'b0;
    m_pc    = 32'd0;
    m_e     = mk_e(15'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      chk("rnd.valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd.pc", ex_pc, m_pc);
        chk_out("rnd", m_e);
      end
      drive($urandom_range(0, 3) != 0, $urandom, gen_inst(),
            ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63)), $urandom);
      ex_allowin = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 15) == 0;
      #1 chk("rnd.allowin", 32'(id_allowin), 32'(!m_valid || ex_allowin));
      acc = id_valid && (!m_valid || ex_allowin) && !flush;
      ea  = ref_dec(id_inst, rs_data, rt_data);
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_pc    = id_pc;
        m_e     = ea;
      end else if (ex_allowin) begin
        m_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
